// File: rtl/gmii_phy_rx_source.sv
// GMII/MII receive-stream source: wraps AXI-stream bytes in preamble/SFD, emits in-band status between frames.
// Beats are registered; gmii_rx_clk_en is high in the cycle each new beat is first visible on gmii_rxd/dv/er.
module gmii_phy_rx_source #(
    parameter int PRESCALE_100   = 5,
    parameter int PRESCALE_10    = 50,
    parameter int PREAMBLE_BYTES = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_rx_clk_en,
    output logic       mii_select,
    input  logic [1:0] cfg_speed,
    input  logic       cfg_link_up,
    input  logic       cfg_full_duplex,
    input  logic [7:0] cfg_ifg,
    output logic       err_underflow
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, DROP, IFG} state_t;

    function automatic logic [7:0] beat_div(input logic [1:0] speed);
        case (speed)
            2'b00:   return 8'(PRESCALE_10);
            2'b01:   return 8'(PRESCALE_100);
            default: return 8'd1;
        endcase
    endfunction

    state_t     state;
    logic [1:0] speed_q;
    logic       duplex_q, active, half, last_q, user_q, ce;
    logic [7:0] cnt, n_cur, byte_q, idle_rxd, ifg_eff;
    logic [4:0] pre_cnt, pre_last;
    logic [8:0] ifg_cnt, ifg_load;

    assign n_cur    = beat_div(speed_q);
    assign ce       = active && (cnt == n_cur - 8'd1);
    assign idle_rxd = {2{duplex_q, speed_q, cfg_link_up}};
    assign ifg_eff  = (cfg_ifg == 8'd0) ? 8'd1 : cfg_ifg;
    // gap is counted in beats, so a nibble-mode byte time is two beats
    assign ifg_load = mii_select ? {ifg_eff, 1'b0} : {1'b0, ifg_eff};
    assign pre_last = mii_select ? 5'(2 * PREAMBLE_BYTES + 1) : 5'(PREAMBLE_BYTES);

    // The byte is taken in the same ce cycle that loads its first beat into the output register.
    assign s_axis_tready = (state == PAYLOAD && ce && !half) || state == DROP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            speed_q        <= 2'b10;
            duplex_q       <= 1'b0;
            mii_select     <= 1'b0;
            active         <= 1'b0;
            cnt            <= '0;
            half           <= 1'b0;
            last_q         <= 1'b0;
            user_q         <= 1'b0;
            byte_q         <= '0;
            pre_cnt        <= '0;
            ifg_cnt        <= '0;
            gmii_rxd       <= '0;
            gmii_rx_dv     <= 1'b0;
            gmii_rx_er     <= 1'b0;
            gmii_rx_clk_en <= 1'b0;
            err_underflow  <= 1'b0;
        end else begin
            active         <= 1'b1;
            gmii_rx_clk_en <= ce;
            err_underflow  <= 1'b0;

            if (state == IDLE) begin
                speed_q    <= cfg_speed;
                duplex_q   <= cfg_full_duplex;
                mii_select <= ~cfg_speed[1];
            end

            if (state == IDLE && beat_div(cfg_speed) != n_cur)
                cnt <= '0;
            else if (cnt == n_cur - 8'd1)
                cnt <= '0;
            else
                cnt <= cnt + 8'd1;

            if (ce) begin
                case (state)
                    IDLE: begin
                        gmii_rx_er <= 1'b0;
                        if (cfg_link_up && s_axis_tvalid) begin
                            gmii_rxd   <= 8'h55;
                            gmii_rx_dv <= 1'b1;
                            pre_cnt    <= 5'd1;
                            state      <= PREAMBLE;
                        end else begin
                            gmii_rxd   <= idle_rxd;
                            gmii_rx_dv <= 1'b0;
                        end
                    end
                    PREAMBLE: begin
                        gmii_rx_dv <= 1'b1;
                        if (pre_cnt == pre_last) begin
                            gmii_rxd <= mii_select ? 8'hDD : 8'hD5;
                            half     <= 1'b0;
                            state    <= PAYLOAD;
                        end else begin
                            gmii_rxd <= 8'h55;
                            pre_cnt  <= pre_cnt + 5'd1;
                        end
                    end
                    PAYLOAD: begin
                        gmii_rx_dv <= 1'b1;
                        if (half) begin
                            gmii_rxd   <= {2{byte_q[7:4]}};
                            gmii_rx_er <= user_q;
                            half       <= 1'b0;
                            if (last_q) begin
                                ifg_cnt <= ifg_load;
                                state   <= IFG;
                            end
                        end else if (s_axis_tvalid) begin
                            byte_q     <= s_axis_tdata;
                            last_q     <= s_axis_tlast;
                            user_q     <= s_axis_tlast & s_axis_tuser;
                            gmii_rxd   <= mii_select ? {2{s_axis_tdata[3:0]}} : s_axis_tdata;
                            gmii_rx_er <= s_axis_tlast & s_axis_tuser;
                            if (mii_select) begin
                                half <= 1'b1;
                            end else if (s_axis_tlast) begin
                                ifg_cnt <= ifg_load;
                                state   <= IFG;
                            end
                        end else begin
                            gmii_rxd      <= 8'h00;
                            gmii_rx_er    <= 1'b1;
                            err_underflow <= 1'b1;
                            state         <= DROP;
                        end
                    end
                    DROP: begin
                        gmii_rxd   <= idle_rxd;
                        gmii_rx_dv <= 1'b0;
                        gmii_rx_er <= 1'b0;
                    end
                    default: begin
                        gmii_rxd   <= idle_rxd;
                        gmii_rx_dv <= 1'b0;
                        gmii_rx_er <= 1'b0;
                        if (ifg_cnt <= 9'd1)
                            state <= IDLE;
                        else
                            ifg_cnt <= ifg_cnt - 9'd1;
                    end
                endcase
            end

            // draining ends on the accepted tlast, independent of beat timing
            if (state == DROP && s_axis_tvalid && s_axis_tlast) begin
                ifg_cnt <= ifg_load;
                state   <= IFG;
            end
        end
    end
endmodule

// File: tb/tb_gmii_phy_rx_source.sv
// Bench for gmii_phy_rx_source: random frames at each speed checked beat-by-beat against a frame-level model.
module tb_gmii_phy_rx_source;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tuser = 1'b0;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv, gmii_rx_er, gmii_rx_clk_en, mii_select, err_underflow;
    logic [1:0] cfg_speed = 2'b10;
    logic       cfg_link_up = 1'b1;
    logic       cfg_full_duplex = 1'b1;
    logic [7:0] cfg_ifg = 8'd12;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int uf_cnt = 0;
    logic [9:0] beats[$];
    logic [9:0] exp_q[$];
    int         ce_stamp[$];
    int         rdy_stamp[$];
    logic [7:0] frame_q[$];

    always #4 clk = ~clk;

    gmii_phy_rx_source dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
        .gmii_rx_clk_en(gmii_rx_clk_en), .mii_select(mii_select),
        .cfg_speed(cfg_speed), .cfg_link_up(cfg_link_up), .cfg_full_duplex(cfg_full_duplex),
        .cfg_ifg(cfg_ifg), .err_underflow(err_underflow)
    );

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (gmii_rx_clk_en) begin
            beats.push_back({gmii_rx_dv, gmii_rx_er, gmii_rxd});
            ce_stamp.push_back(cyc);
        end
        if (err_underflow) uf_cnt = uf_cnt + 1;
        if (s_axis_tready) rdy_stamp.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Expected beat stream of one frame: preamble+SFD, data beats, optional underflow/drain, then the gap.
    task automatic model_frame(input bit mii, input logic [3:0] st, input logic u, input int gap_at, input int ifg);
        int n, bpb, eff;
        logic e;
        logic [7:0] v;
        n   = frame_q.size();
        bpb = mii ? 2 : 1;
        eff = (ifg == 0) ? 1 : ifg;
        for (int k = 0; k < 8 * bpb - 1; k++) exp_q.push_back({2'b10, 8'h55});
        exp_q.push_back({2'b10, mii ? 8'hDD : 8'hD5});
        for (int b = 0; b < n; b++) begin
            if (b == gap_at) begin
                exp_q.push_back({2'b11, 8'h00});
                // at 1000M the drain takes one beat per remaining byte
                for (int k = 0; k < n - b; k++) exp_q.push_back({2'b00, st, st});
                break;
            end
            e = u && (b == n - 1);
            v = frame_q[b];
            if (mii) begin
                exp_q.push_back({1'b1, e, v[3:0], v[3:0]});
                exp_q.push_back({1'b1, e, v[7:4], v[7:4]});
            end else begin
                exp_q.push_back({1'b1, e, v});
            end
        end
        for (int k = 0; k < eff * bpb; k++) exp_q.push_back({2'b00, st, st});
    endtask

    task automatic drive_frame(input logic u, input int gap_at, input int chg_at, input bit hold);
        int i, guard, n;
        bit gapped, rdy;
        i = 0; guard = 0; gapped = 1'b0; n = frame_q.size();
        while (i < n && guard < 20000) begin
            @(negedge clk);
            if (i == chg_at) cfg_speed = 2'b10;
            if (i == gap_at && !gapped) begin
                s_axis_tvalid = 1'b0;
            end else begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = frame_q[i];
                s_axis_tlast  = (i == n - 1);
                s_axis_tuser  = u && (i == n - 1);
            end
            rdy = s_axis_tready;
            @(posedge clk);
            if (rdy) begin
                if (s_axis_tvalid) i++;
                else gapped = 1'b1;
            end
            guard++;
        end
        #1;
        if (!hold) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tuser  = 1'b0;
        end
        chk("drive_done", i, n);
    endtask

    task automatic check_beats(input string tag);
        int first, guard;
        first = -1; guard = 0;
        while (guard < 30000) begin
            first = -1;
            for (int k = 0; k < beats.size(); k++)
                if (beats[k][9]) begin first = k; break; end
            if (first >= 0 && beats.size() >= first + exp_q.size()) break;
            @(negedge clk);
            guard++;
        end
        if (first >= 0 && beats.size() >= first + exp_q.size()) begin
            for (int k = 0; k < exp_q.size(); k++) begin
                ncmp++;
                assert (beats[first + k] === exp_q[k]) else begin
                    nfail++;
                    $error("FAIL %s beat %0d observed %h expected %h", tag, k, beats[first + k], exp_q[k]);
                end
            end
        end else begin
            ncmp++;
            nfail++;
            $error("FAIL %s_timeout observed %0d beats expected %0d", tag, beats.size(), exp_q.size());
        end
    endtask

    task automatic check_period(input string tag, input int n);
        ce_stamp.delete();
        repeat (6 * n + 2) @(negedge clk);
        chk({tag, "_count"}, (ce_stamp.size() >= 6) ? 1 : 0, 1);
        for (int k = 1; k < ce_stamp.size(); k++) chk(tag, ce_stamp[k] - ce_stamp[k-1], n);
    endtask

    task automatic random_frame(input int lo, input int hi);
        int len;
        frame_q.delete();
        len = $urandom_range(hi, lo);
        for (int k = 0; k < len; k++) frame_q.push_back(8'($urandom_range(255, 0)));
    endtask

    initial begin
        logic u;
        #20;
        chk("rst_rxd", gmii_rxd, 0);
        chk("rst_dv", gmii_rx_dv, 0);
        chk("rst_er", gmii_rx_er, 0);
        chk("rst_clk_en", gmii_rx_clk_en, 0);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_mii", mii_select, 0);
        chk("rst_uf", err_underflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_dv", gmii_rx_dv, 0);
        chk("idle_rxd", gmii_rxd, 8'hDD);
        chk("gmii_mode", mii_select, 0);
        check_period("ce_1000", 1);

        // 1000M: 64-byte ramp then a random frame with tuser, back to back
        beats.delete(); exp_q.delete();
        frame_q.delete();
        for (int k = 1; k <= 64; k++) frame_q.push_back(8'(k));
        model_frame(1'b0, 4'hD, 1'b0, -1, 12);
        drive_frame(1'b0, -1, -1, 1'b1);
        random_frame(1, 20);
        model_frame(1'b0, 4'hD, 1'b1, -1, 12);
        drive_frame(1'b1, -1, -1, 1'b0);
        check_beats("b2b_1000");

        // 1000M underflow after byte 10
        repeat (20) @(negedge clk);
        beats.delete(); exp_q.delete(); uf_cnt = 0;
        cfg_ifg = 8'($urandom_range(8, 1));
        random_frame(16, 30);
        model_frame(1'b0, 4'hD, 1'b1, 10, int'(cfg_ifg));
        drive_frame(1'b1, 10, -1, 1'b0);
        check_beats("underflow");
        chk("uf_pulses", uf_cnt, 1);

        // 1000M ifg=0 behaves as 1, back to back
        repeat (20) @(negedge clk);
        beats.delete(); exp_q.delete();
        cfg_ifg = 8'd0;
        random_frame(1, 6);
        u = 1'($urandom_range(1, 0));
        model_frame(1'b0, 4'hD, u, -1, 0);
        drive_frame(u, -1, -1, 1'b1);
        random_frame(1, 6);
        model_frame(1'b0, 4'hD, 1'b0, -1, 0);
        drive_frame(1'b0, -1, -1, 1'b0);
        check_beats("ifg0");

        // 100M nibble mode
        repeat (20) @(negedge clk);
        cfg_speed = 2'b01; cfg_ifg = 8'd2;
        repeat (20) @(negedge clk);
        chk("mii_100", mii_select, 1);
        check_period("ce_100", 5);
        beats.delete(); exp_q.delete(); rdy_stamp.delete();
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'h3C);
        model_frame(1'b1, 4'hB, 1'b0, -1, 2);
        drive_frame(1'b0, -1, -1, 1'b0);
        check_beats("nib_100");
        chk("rdy_pulses", rdy_stamp.size(), 2);
        chk("rdy_spacing", (rdy_stamp.size() >= 2) ? rdy_stamp[1] - rdy_stamp[0] : 0, 10);

        // speed change to 1000M mid-frame takes effect only once idle
        repeat (20) @(negedge clk);
        beats.delete(); exp_q.delete();
        random_frame(3, 6);
        model_frame(1'b1, 4'hB, 1'b1, -1, 2);
        drive_frame(1'b1, -1, 1, 1'b0);
        check_beats("spd_chg");
        repeat (20) @(negedge clk);
        chk("spd_chg_idle", mii_select, 0);

        // 10M with link down, then up
        cfg_speed = 2'b00; cfg_full_duplex = 1'b0; cfg_link_up = 1'b0; cfg_ifg = 8'd1;
        repeat (10) @(negedge clk);
        rdy_stamp.delete();
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h99;
        check_period("ce_10", 50);
        chk("lnk_dn_rdy", rdy_stamp.size(), 0);
        chk("lnk_dn_beat", (beats.size() > 0) ? beats[beats.size()-1] : 10'h3FF, {2'b00, 8'h00});
        chk("lnk_dn_mii", mii_select, 1);
        beats.delete(); exp_q.delete();
        random_frame(1, 1);
        u = 1'($urandom_range(1, 0));
        model_frame(1'b1, 4'h1, u, -1, 1);
        cfg_link_up = 1'b1;
        drive_frame(u, -1, -1, 1'b0);
        check_beats("lnk_up_10");

        // reset in the middle of a 1000M payload
        cfg_speed = 2'b10; cfg_full_duplex = 1'b1;
        repeat (120) @(negedge clk);
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h77; s_axis_tlast = 1'b0;
        repeat (30) @(negedge clk);
        chk("pre_rst_dv", gmii_rx_dv, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_dv", gmii_rx_dv, 0);
        chk("arst_rxd", gmii_rxd, 0);
        chk("arst_clk_en", gmii_rx_clk_en, 0);
        chk("arst_tready", s_axis_tready, 0);
        s_axis_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        beats.delete();
        for (int g = 0; g < 100 && beats.size() == 0; g++) @(negedge clk);
        chk("post_rst_beat", (beats.size() > 0) ? beats[0] : 10'h3FF, {2'b00, 8'hDD});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
